mc_datapath: RTL and testbench
==============================

// Module: mc_datapath
// PURPOSE
//  Multicycle MIPS datapath, driven by the control FSM's signals: PCWriteCond/PCWrite/IorD/MemRead/MemWrite/
//  MemtoReg/IRWrite/PCSource/ALUOp/ALUSrcB/ALUSrcA/RegWrite/RegDst. Returns opcode IR[31:26] to the FSM.
//  Holds PC, IR, MDR, A, B and ALUOut, a 32x32 register file and the ALU. Drives a single unified memory port.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value after reset
// PORTS
//  i_clk          in   1   clock, all state updates on rising edge
//  i_rst_n        in   1   asynchronous, active-low reset
//  i_PCWriteCond  in   1   PC write if ALU zero
//  i_PCWrite      in   1   unconditional PC write
//  i_IorD         in   1   mem addr: 0=PC, 1=ALUOut
//  i_MemRead      in   1   memory read request
//  i_MemWrite     in   1   memory write request
//  i_MemtoReg     in   1   rf write data: 0=ALUOut, 1=MDR
//  i_IRWrite      in   1   load IR from memory data
//  i_PCSource     in   2   00 ALU result, 01 ALUOut, 10 jump target, 11 reserved (PC held)
//  i_ALUOp        in   2   00 add, 01 sub, 10 funct-decoded, 11 add
//  i_ALUSrcB      in   2   00 B, 01 const 4, 10 sext(imm16), 11 sext(imm16)<<2
//  i_ALUSrcA      in   1   0=PC, 1=A
//  i_RegWrite     in   1   register file write enable
//  i_RegDst       in   1   dest reg: 0=rt IR[20:16], 1=rd IR[15:11]
//  o_op           out  6   IR[31:26], to FSM i_op
//  o_mem_addr     out  32  byte address
//  o_mem_wdata    out  32  = B register
//  o_mem_read     out  1   = i_MemRead & ~i_MemWrite
//  o_mem_write    out  1   = i_MemWrite
//  i_mem_rdata    in   32  read data, combinational (valid in same cycle as o_mem_addr)
//  o_pc           out  32  current PC (debug)
//  o_zero         out  1   ALU result == 0 (combinational)
// BEHAVIOUR
//  Reset (async, i_rst_n=0): PC=RESET_PC. IR, MDR, A, B, ALUOut and all 32 registers = 0, so o_op=0.
//  Combinational per cycle:
//   - ALU inputs from the ALUSrcA/ALUSrcB muxes.
//   - ALUOp=10 decodes funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed).
//     Any other funct gives add.
//  Every rising edge (unconditional latches):
//   - MDR <= i_mem_rdata
//   - A <= rf[IR[25:21]], B <= rf[IR[20:16]]
//   - ALUOut <= ALU result
//  IR <= i_mem_rdata only when i_IRWrite=1.
//  PC write enable = PCWrite | (PCWriteCond & o_zero).
//   - Jump target = {PC[31:28], IR[25:0], 2'b00}.
//   - PCSource=11 inhibits the write.
//  Fetch cycle (IRWrite, PCWrite, IorD=0, SrcA=0, SrcB=01, PCSource=00): IR <= mem[PC_old], PC <= PC_old+4.
//  Arithmetic is 32-bit modulo 2^32. Overflow is ignored; there is no exception.
//  Register file:
//   - 2 async read ports, 1 sync write port.
//   - Writes to $0 are dropped; $0 always reads 0.
//   - Same-edge write and read of one register: A/B capture the OLD value (no bypass).
//  Read and write requested together: the write wins and o_mem_read is forced to 0.
//  The datapath never stalls; the FSM owns all sequencing.
// STRUCTURE
//  mc_defs.vh (shared with FSM): opcodes (Rtype, lw, sw, beq, addi, j), funct codes, ALUOp/ALUSrcB/PCSource encodings.
//  Sub-module mc_regfile: 32x32, async reset, $0 hardwired.
//  ALU, sign-extend and muxes stay inline.
// TESTING
//  1. Reset asserted mid-cycle: all regs clear immediately; o_pc=RESET_PC and o_op=0 before the next edge.
//  2. Fetch, mem returns 32'h8C22_0004 (lw $2,4($1)) at PC=0 -> PC=4, o_op=6'b100011.
//     A=rf[1] on the next edge.
//  3. lw sequence, rf[1]=0x10, mem[0x14]=0xDEAD_BEEF:
//     -> o_mem_addr=0x14 with IorD=1, MDR=0xDEADBEEF, rf[2]=0xDEADBEEF.
//  4. R-type, rf[3]=5, rf[4]=-3:
//     - add -> 2
//     - sub -> 8
//     - slt rd=$5 -> rf[5]=0 (5 < -3 false)
//     - write to rd=$0 -> rf[0] still 0
//  5. beq, A=B=7, imm=-2, PC=0x20, prior ALUOut=PC+imm<<2:
//     - taken -> PC=0x18
//     - A!=B -> PC unchanged
//  6. j with IR[25:0]=26'h100, PC=0x4000_0004 -> PC=0x4000_0400.
//     sw -> o_mem_write=1, o_mem_wdata=B, o_mem_read=0.

Source files
------------

// File: rtl/mc_datapath_pkg.sv
// Shared encodings for the multicycle MIPS datapath and its control FSM:
// opcodes, funct codes, control-field encodings and the ALU control decode.
package mc_datapath_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_ADD2  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SRCB_REG     = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } alu_srcb_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_HOLD   = 2'b11
   } pc_src_e;

   typedef enum logic [2:0] {
      ALU_FN_ADD,
      ALU_FN_SUB,
      ALU_FN_AND,
      ALU_FN_OR,
      ALU_FN_SLT
   } alu_fn_e;

   // Unrecognised funct codes fall back to add rather than trapping.
   function automatic alu_fn_e alu_decode(input alu_op_e alu_op, input logic [5:0] funct);
      alu_fn_e fn;
      fn = ALU_FN_ADD;
      case (alu_op)
         ALUOP_SUB:   fn = ALU_FN_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_SUB:  fn = ALU_FN_SUB;
               FN_AND:  fn = ALU_FN_AND;
               FN_OR:   fn = ALU_FN_OR;
               FN_SLT:  fn = ALU_FN_SLT;
               default: fn = ALU_FN_ADD;
            endcase
         end
         default:     fn = ALU_FN_ADD;
      endcase
      return fn;
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, $0 hardwired to zero, no write-to-read bypass.
module mc_regfile (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [4:0]  i_ra1,
   input  logic [4:0]  i_ra2,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2,
   input  logic        i_we,
   input  logic [4:0]  i_wa,
   input  logic [31:0] i_wd
);

   logic [31:0] regs [32];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (i_we && (i_wa != 5'd0)) begin
         regs[i_wa] <= i_wd;
      end
   end

   assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : regs[i_ra1];
   assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : regs[i_ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, register file, inline ALU
// and muxes. All sequencing comes from the external control FSM.
module mc_datapath
   import mc_datapath_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_PCWriteCond,
   input  logic        i_PCWrite,
   input  logic        i_IorD,
   input  logic        i_MemRead,
   input  logic        i_MemWrite,
   input  logic        i_MemtoReg,
   input  logic        i_IRWrite,
   input  logic [1:0]  i_PCSource,
   input  logic [1:0]  i_ALUOp,
   input  logic [1:0]  i_ALUSrcB,
   input  logic        i_ALUSrcA,
   input  logic        i_RegWrite,
   input  logic        i_RegDst,
   output logic [5:0]  o_op,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic        o_mem_read,
   output logic        o_mem_write,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_pc,
   output logic        o_zero
);

   logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, alu_out_q;
   logic [31:0] rf_rd1, rf_rd2;
   logic [31:0] imm_sext, alu_a, alu_b, alu_result, pc_next, jump_target;
   logic [31:0] rf_wd;
   logic [4:0]  rf_wa;
   logic        pc_we;
   alu_fn_e     alu_fn;

   mc_regfile u_regfile (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_ra1   (ir_q[25:21]),
      .i_ra2   (ir_q[20:16]),
      .o_rd1   (rf_rd1),
      .o_rd2   (rf_rd2),
      .i_we    (i_RegWrite),
      .i_wa    (rf_wa),
      .i_wd    (rf_wd)
   );

   assign rf_wa       = i_RegDst ? ir_q[15:11] : ir_q[20:16];
   assign rf_wd       = i_MemtoReg ? mdr_q : alu_out_q;
   assign imm_sext    = {{16{ir_q[15]}}, ir_q[15:0]};
   assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

   always_comb begin
      alu_a = i_ALUSrcA ? a_q : pc_q;
      case (alu_srcb_e'(i_ALUSrcB))
         SRCB_REG:     alu_b = b_q;
         SRCB_FOUR:    alu_b = 32'd4;
         SRCB_IMM:     alu_b = imm_sext;
         SRCB_IMM_SH2: alu_b = {imm_sext[29:0], 2'b00};
         default:      alu_b = b_q;
      endcase
   end

   always_comb begin
      alu_fn = alu_decode(alu_op_e'(i_ALUOp), ir_q[5:0]);
      case (alu_fn)
         ALU_FN_SUB: alu_result = alu_a - alu_b;
         ALU_FN_AND: alu_result = alu_a & alu_b;
         ALU_FN_OR:  alu_result = alu_a | alu_b;
         ALU_FN_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default:    alu_result = alu_a + alu_b;
      endcase
   end

   assign o_zero = (alu_result == 32'd0);

   // The reserved PCSource encoding inhibits the PC write entirely.
   always_comb begin
      pc_next = pc_q;
      case (pc_src_e'(i_PCSource))
         PCSRC_ALU:    pc_next = alu_result;
         PCSRC_ALUOUT: pc_next = alu_out_q;
         PCSRC_JUMP:   pc_next = jump_target;
         default:      pc_next = pc_q;
      endcase
   end

   assign pc_we = (i_PCWrite | (i_PCWriteCond & o_zero)) &
                  (pc_src_e'(i_PCSource) != PCSRC_HOLD);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         mdr_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
      end else begin
         mdr_q     <= i_mem_rdata;
         a_q       <= rf_rd1;
         b_q       <= rf_rd2;
         alu_out_q <= alu_result;
         if (i_IRWrite) ir_q <= i_mem_rdata;
         if (pc_we)     pc_q <= pc_next;
      end
   end

   assign o_op        = ir_q[31:26];
   assign o_pc        = pc_q;
   assign o_mem_addr  = i_IorD ? alu_out_q : pc_q;
   assign o_mem_wdata = b_q;
   assign o_mem_write = i_MemWrite;
   assign o_mem_read  = i_MemRead & ~i_MemWrite;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: drives control words step by step and
// checks outputs against hand-computed values with immediate assertions.
module tb_mc_datapath;
   import mc_datapath_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write_cond, pc_write, iord, mem_read_req, mem_write_req;
   logic        mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst;
   logic [1:0]  pc_source, alu_op, alu_src_b;
   logic [31:0] mem_rdata;
   logic [5:0]  op;
   logic [31:0] mem_addr, mem_wdata, pc;
   logic        mem_read, mem_write, zero;

   int n_checks = 0;
   int n_err    = 0;

   mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_PCWriteCond (pc_write_cond),
      .i_PCWrite     (pc_write),
      .i_IorD        (iord),
      .i_MemRead     (mem_read_req),
      .i_MemWrite    (mem_write_req),
      .i_MemtoReg    (mem_to_reg),
      .i_IRWrite     (ir_write),
      .i_PCSource    (pc_source),
      .i_ALUOp       (alu_op),
      .i_ALUSrcB     (alu_src_b),
      .i_ALUSrcA     (alu_src_a),
      .i_RegWrite    (reg_write),
      .i_RegDst      (reg_dst),
      .o_op          (op),
      .o_mem_addr    (mem_addr),
      .o_mem_wdata   (mem_wdata),
      .o_mem_read    (mem_read),
      .o_mem_write   (mem_write),
      .i_mem_rdata   (mem_rdata),
      .o_pc          (pc),
      .o_zero        (zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pc_write_cond = 0; pc_write = 0; iord = 0; mem_read_req = 0; mem_write_req = 0;
      mem_to_reg = 0; ir_write = 0; alu_src_a = 0; reg_write = 0; reg_dst = 0;
      pc_source = 2'b00; alu_op = 2'b00; alu_src_b = 2'b00;
   endtask

   task automatic load_ir(input logic [31:0] instr);
      idle(); ir_write = 1; mem_rdata = instr; step(); idle();
   endtask

   // rf[r] <= val via the MDR path
   task automatic write_reg(input logic [4:0] r, input logic [31:0] val);
      load_ir({OP_LW, 5'd0, r, 16'd0});
      mem_rdata = val; step();
      reg_write = 1; mem_to_reg = 1; reg_dst = 0; step(); idle();
   endtask

   // observe rf[r] through B / o_mem_wdata
   task automatic read_chk(input string tag, input logic [4:0] r, input logic [31:0] exp);
      load_ir({OP_SW, 5'd0, r, 16'd0});
      step();
      chk(tag, mem_wdata, exp);
   endtask

   task automatic set_pc(input logic [31:0] val);
      write_reg(5'd10, val);
      load_ir({OP_ADDI, 5'd10, 5'd0, 16'd0});
      step();
      alu_src_a = 1; alu_src_b = 2'b10; alu_op = 2'b00; pc_write = 1; pc_source = 2'b00;
      step(); idle();
   endtask

   task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [5:0] funct);
      load_ir({OP_RTYPE, rs, rt, rd, 5'd0, funct});
      step();
      alu_src_a = 1; alu_src_b = 2'b00; alu_op = 2'b10; step(); idle();
      reg_write = 1; reg_dst = 1; mem_to_reg = 0; step(); idle();
   endtask

   initial begin
      rst_n = 0; mem_rdata = '0; idle();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pc", pc, 32'h0);
      chk("reset_op", {26'd0, op}, 32'h0);
      chk("reset_b", mem_wdata, 32'h0);
      rst_n = 1;
      step();

      // lw $2,4($1) fetch and execution
      write_reg(5'd1, 32'h10);
      ir_write = 1; pc_write = 1; iord = 0; alu_src_a = 0; alu_src_b = 2'b01;
      alu_op = 2'b00; pc_source = 2'b00; mem_read_req = 1;
      mem_rdata = 32'h8C22_0004;
      #1;
      chk("fetch_addr", mem_addr, 32'h0);
      chk("fetch_read", {31'd0, mem_read}, 32'h1);
      step(); idle();
      chk("fetch_pc", pc, 32'h4);
      chk("fetch_op", {26'd0, op}, {26'd0, OP_LW});
      step();
      alu_src_a = 1; alu_src_b = 2'b10; alu_op = 2'b00; step(); idle();
      iord = 1; mem_read_req = 1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("lw_addr", mem_addr, 32'h14);
      chk("lw_read", {31'd0, mem_read}, 32'h1);
      step(); idle();
      reg_write = 1; mem_to_reg = 1; reg_dst = 0; step(); idle();
      chk("lw_pc_hold", pc, 32'h4);
      read_chk("lw_rf2", 5'd2, 32'hDEAD_BEEF);

      // R-type, rf[3]=5, rf[4]=-3
      write_reg(5'd3, 32'd5);
      write_reg(5'd4, 32'hFFFF_FFFD);
      rtype(5'd3, 5'd4, 5'd5, FN_ADD);  read_chk("r_add", 5'd5, 32'd2);
      rtype(5'd3, 5'd4, 5'd6, FN_SUB);  read_chk("r_sub", 5'd6, 32'd8);
      rtype(5'd3, 5'd4, 5'd5, FN_SLT);  read_chk("r_slt_false", 5'd5, 32'd0);
      rtype(5'd4, 5'd3, 5'd8, FN_SLT);  read_chk("r_slt_true", 5'd8, 32'd1);
      rtype(5'd3, 5'd4, 5'd9, FN_AND);  read_chk("r_and", 5'd9, 32'd5);
      rtype(5'd3, 5'd4, 5'd11, FN_OR);  read_chk("r_or", 5'd11, 32'hFFFF_FFFD);
      rtype(5'd3, 5'd4, 5'd12, 6'h21);  read_chk("r_funct_dflt", 5'd12, 32'd2);
      rtype(5'd3, 5'd4, 5'd0, FN_ADD);  read_chk("r_rd0", 5'd0, 32'd0);
      write_reg(5'd7, 32'd100);
      rtype(5'd3, 5'd7, 5'd7, FN_ADD);
      chk("no_bypass_b", mem_wdata, 32'd100);
      read_chk("no_bypass_rf", 5'd7, 32'd105);

      // beq, imm=-2 from PC=0x20
      write_reg(5'd13, 32'd7);
      write_reg(5'd14, 32'd7);
      set_pc(32'h20);
      chk("set_pc", pc, 32'h20);
      load_ir({OP_BEQ, 5'd13, 5'd14, 16'hFFFE});
      alu_src_a = 0; alu_src_b = 2'b11; alu_op = 2'b00; step(); idle();
      alu_src_a = 1; alu_src_b = 2'b00; alu_op = 2'b01; pc_write_cond = 1; pc_source = 2'b01;
      #1;
      chk("beq_zero", {31'd0, zero}, 32'h1);
      step(); idle();
      chk("beq_taken", pc, 32'h18);
      set_pc(32'h20);
      load_ir({OP_BEQ, 5'd13, 5'd3, 16'hFFFE});
      alu_src_a = 0; alu_src_b = 2'b11; alu_op = 2'b00; step(); idle();
      alu_src_a = 1; alu_src_b = 2'b00; alu_op = 2'b01; pc_write_cond = 1; pc_source = 2'b01;
      #1;
      chk("bne_zero", {31'd0, zero}, 32'h0);
      step(); idle();
      chk("beq_not_taken", pc, 32'h20);

      // jump and reserved PCSource
      set_pc(32'h4000_0004);
      load_ir({OP_J, 26'h100});
      pc_write = 1; pc_source = 2'b10; step(); idle();
      chk("j_target", pc, 32'h4000_0400);
      pc_write = 1; pc_source = 2'b11; alu_src_b = 2'b01; step(); idle();
      chk("pcsrc_hold", pc, 32'h4000_0400);

      // sw with read+write requested together
      load_ir({OP_SW, 5'd0, 5'd3, 16'd0});
      step();
      iord = 1; mem_write_req = 1; mem_read_req = 1;
      #1;
      chk("sw_write", {31'd0, mem_write}, 32'h1);
      chk("sw_read_off", {31'd0, mem_read}, 32'h0);
      chk("sw_wdata", mem_wdata, 32'd5);
      step(); idle();

      // asynchronous reset asserted mid-cycle
      @(negedge clk);
      rst_n = 0;
      #1;
      chk("arst_pc", pc, 32'h0);
      chk("arst_op", {26'd0, op}, 32'h0);
      chk("arst_b", mem_wdata, 32'h0);
      #1;
      rst_n = 1;
      step();
      read_chk("arst_rf3", 5'd3, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
